// File: rtl/pi_pkg.sv
// Shared definitions for the PI control loop datapath:
// mode encodings, default widths and the saturating clamp helper.
package pi_pkg;

    localparam int W_DEF     = 8;
    localparam int KW_DEF    = 8;
    localparam int FRAC_DEF  = 6;
    localparam int ACC_W_DEF = 16;
    localparam int CH_DEF    = 4;
    localparam int CLAMP_W   = 64;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_HOLD  = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef struct packed {
        logic signed [CLAMP_W-1:0] val;
        logic                      sat;
    } clamp_t;

    // Upper limit applied first, so lo > hi resolves to lo.
    function automatic clamp_t clamp(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] hi,
        input logic signed [CLAMP_W-1:0] lo
    );
        clamp_t r;
        r.val = v;
        r.sat = 1'b0;
        if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end
        if ($signed(r.val) < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pi_integrator_mc_if.sv
// Sample/result bundle between the error front end, the
// integral engine and the PI output summer.
interface pi_integrator_mc_if
    import pi_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int KW    = KW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CH_W  = 2
);
    logic                    in_valid;
    logic [CH_W-1:0]         in_ch;
    logic signed [W-1:0]     yk;
    logic signed [W-1:0]     rk;
    logic [KW-1:0]           ki;
    logic [1:0]              mode;
    logic signed [ACC_W-1:0] lim_hi;
    logic signed [ACC_W-1:0] lim_lo;
    logic                    out_valid;
    logic [CH_W-1:0]         out_ch;
    logic signed [ACC_W-1:0] ik;
    logic                    sat_flag;

    modport master (
        output in_valid, in_ch, yk, rk, ki, mode, lim_hi, lim_lo,
        input  out_valid, out_ch, ik, sat_flag
    );

    modport slave (
        input  in_valid, in_ch, yk, rk, ki, mode, lim_hi, lim_lo,
        output out_valid, out_ch, ik, sat_flag
    );
endinterface

// File: rtl/pi_acc_bank.sv
// Per-channel integral accumulators: async read port,
// single synchronous write port, cleared by reset.
module pi_acc_bank #(
    parameter int CH    = 4,
    parameter int ACC_W = 16,
    parameter int CH_W  = $clog2(CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_W-1:0]         rd_idx,
    output logic signed [ACC_W-1:0] rd_data,
    input  logic                    we,
    input  logic [CH_W-1:0]         wr_idx,
    input  logic signed [ACC_W-1:0] wr_data
);
    logic signed [ACC_W-1:0] acc_q [CH];
    logic signed [ACC_W-1:0] acc_d [CH];

    assign rd_data = acc_q[rd_idx];

    always_comb begin
        acc_d = acc_q;
        if (we) acc_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/pi_integrator_mc.sv
// Multi-channel integral-term engine: error, gain scaling and
// clamped per-channel accumulation in a 3-stage pipeline.
module pi_integrator_mc
    import pi_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int KW    = KW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CH    = CH_DEF,
    parameter int CH_W  = $clog2(CH)
) (
    input logic clk,
    input logic rst_n,
    pi_integrator_mc_if.slave bus
);
    localparam int PW = W + KW + 2;

    logic                    ch_ok;
    logic                    v1_q, v1_d, v2_q, v2_d;
    logic [CH_W-1:0]         ch1_q, ch1_d, ch2_q, ch2_d;
    logic signed [W:0]       e1_q, e1_d;
    logic [KW-1:0]           ki1_q, ki1_d;
    mode_e                   md1_q, md1_d, md2_q, md2_d;
    logic signed [ACC_W-1:0] p2_q, p2_d;
    logic                    ov_q, ov_d;
    logic [CH_W-1:0]         och_q, och_d;
    logic signed [ACC_W-1:0] ik_q, ik_d;
    logic                    sat_q, sat_d;

    logic signed [PW-1:0]      ea, kb, prod;
    logic signed [CLAMP_W-1:0] pw, sum;
    logic signed [ACC_W-1:0]   acc_rd, res;
    logic                      rsat, we;
    clamp_t                    cl;

    // Out-of-range channel indices only exist when CH is not a power of two.
    if (CH == (1 << CH_W)) begin : g_full
        assign ch_ok = 1'b1;
    end else begin : g_part
        assign ch_ok = (bus.in_ch < CH_W'(CH));
    end

    pi_acc_bank #(.CH(CH), .ACC_W(ACC_W), .CH_W(CH_W)) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (ch2_q),
        .rd_data (acc_rd),
        .we      (we),
        .wr_idx  (ch2_q),
        .wr_data (res)
    );

    always_comb begin
        v1_d  = bus.in_valid & ch_ok;
        ch1_d = bus.in_ch;
        e1_d  = {bus.rk[W-1], bus.rk} - {bus.yk[W-1], bus.yk};
        ki1_d = bus.ki;
        md1_d = mode_e'(bus.mode);

        ea    = PW'(e1_q);
        kb    = PW'({1'b0, ki1_q});
        prod  = ea * kb;
        pw    = CLAMP_W'(prod >>> FRAC);
        p2_d  = pw[ACC_W-1:0];
        v2_d  = v1_q;
        ch2_d = ch1_q;
        md2_d = md1_q;

        sum  = CLAMP_W'(acc_rd) + CLAMP_W'(p2_q);
        cl   = clamp(sum, CLAMP_W'(bus.lim_hi), CLAMP_W'(bus.lim_lo));
        res  = acc_rd;
        rsat = 1'b0;
        we   = 1'b0;
        case (md2_q)
            MODE_RUN: begin
                res  = cl.val[ACC_W-1:0];
                rsat = cl.sat;
                we   = v2_q;
            end
            MODE_CLEAR: begin
                res = '0;
                we  = v2_q;
            end
            default: ;
        endcase

        ov_d  = v2_q;
        och_d = v2_q ? ch2_q : och_q;
        ik_d  = v2_q ? res : ik_q;
        sat_d = v2_q ? rsat : sat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            ch1_q <= '0;
            e1_q  <= '0;
            ki1_q <= '0;
            md1_q <= MODE_RUN;
            v2_q  <= 1'b0;
            ch2_q <= '0;
            p2_q  <= '0;
            md2_q <= MODE_RUN;
            ov_q  <= 1'b0;
            och_q <= '0;
            ik_q  <= '0;
            sat_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            ch1_q <= ch1_d;
            e1_q  <= e1_d;
            ki1_q <= ki1_d;
            md1_q <= md1_d;
            v2_q  <= v2_d;
            ch2_q <= ch2_d;
            p2_q  <= p2_d;
            md2_q <= md2_d;
            ov_q  <= ov_d;
            och_q <= och_d;
            ik_q  <= ik_d;
            sat_q <= sat_d;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_ch    = och_q;
    assign bus.ik        = ik_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_pi_integrator_mc.sv
// Directed-vector bench for pi_integrator_mc: table of samples with
// hand-computed results plus reset and odd-channel-count sequences.
module tb_pi_integrator_mc;

    typedef struct {
        logic               v;
        logic [1:0]         ch;
        logic signed [7:0]  rk;
        logic signed [7:0]  yk;
        logic [7:0]         ki;
        logic [1:0]         md;
        logic               ev;
        logic signed [15:0] eik;
        logic               esat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nmis = 0;
    int   nv = 0;
    vec_t vt [48];

    always #5 clk = ~clk;

    pi_integrator_mc_if #(.W(8), .KW(8), .ACC_W(16), .CH_W(2)) bus ();
    pi_integrator_mc_if #(.W(8), .KW(8), .ACC_W(16), .CH_W(2)) bus3 ();

    pi_integrator_mc #(.W(8), .KW(8), .FRAC(6), .ACC_W(16), .CH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pi_integrator_mc #(.W(8), .KW(8), .FRAC(6), .ACC_W(16), .CH(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic add(input logic v, input int ch, input int rk,
                       input int yk, input int ki, input int md,
                       input logic ev, input int eik, input logic esat);
        vt[nv].v    = v;
        vt[nv].ch   = 2'(ch);
        vt[nv].rk   = 8'(rk);
        vt[nv].yk   = 8'(yk);
        vt[nv].ki   = 8'(ki);
        vt[nv].md   = 2'(md);
        vt[nv].ev   = ev;
        vt[nv].eik  = 16'(eik);
        vt[nv].esat = esat;
        nv++;
    endtask

    task automatic check(input string nm, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        bus.in_valid = x.v;
        bus.in_ch    = x.ch;
        bus.rk       = x.rk;
        bus.yk       = x.yk;
        bus.ki       = x.ki;
        bus.mode     = x.md;
    endtask

    task automatic check_vec(input int i);
        logic ok;
        nvec++;
        if (vt[i].ev)
            ok = (bus.out_valid === 1'b1) && (bus.out_ch === vt[i].ch) &&
                 (bus.ik === vt[i].eik) && (bus.sat_flag === vt[i].esat);
        else
            ok = (bus.out_valid === 1'b0);
        if (!ok) begin
            nmis++;
            $display("FAIL vec%0d: got v=%b ch=%0d ik=%0d sat=%b, expected v=%b ch=%0d ik=%0d sat=%b",
                     i, bus.out_valid, bus.out_ch, bus.ik, bus.sat_flag,
                     vt[i].ev, vt[i].ch, vt[i].eik, vt[i].esat);
        end
    endtask

    // Vector i is driven in iteration i and its result is visible in iteration i+2.
    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi + 2; i++) begin
            if (i <= hi) drive(vt[i]);
            else bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (i - 2 >= lo) check_vec(i - 2);
        end
    endtask

    initial begin
        // 0..23: lim +/-1000
        add(1, 0, 10, 3, 64, 0, 1, 7, 0);
        add(1, 0, 10, 3, 64, 0, 1, 14, 0);
        add(1, 1, 3, 0, 32, 0, 1, 1, 0);
        add(1, 1, 0, 3, 32, 0, 1, -1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2, 1, 0, 0);
        add(1, 1, 5, 0, 64, 0, 1, 5, 0);
        add(1, 3, 0, 4, 64, 0, 1, -4, 0);
        add(1, 1, 5, 0, 64, 0, 1, 10, 0);
        add(1, 3, 0, 4, 64, 0, 1, -8, 0);
        add(1, 1, 5, 0, 64, 0, 1, 15, 0);
        add(1, 3, 0, 4, 64, 0, 1, -12, 0);
        add(1, 1, 5, 0, 64, 0, 1, 20, 0);
        add(1, 3, 0, 4, 64, 0, 1, -16, 0);
        add(1, 0, 0, 0, 64, 1, 1, 14, 0);
        add(1, 2, 0, 0, 64, 1, 1, 0, 0);
        add(1, 1, 0, 0, 64, 1, 1, 20, 0);
        add(1, 0, 9, 0, 64, 1, 1, 14, 0);
        add(1, 0, 0, 0, 64, 2, 1, 0, 0);
        add(1, 0, 2, 0, 64, 0, 1, 2, 0);
        add(1, 3, 50, 0, 0, 0, 1, -16, 0);
        add(1, 3, 127, -128, 255, 0, 1, 1000, 0);
        add(1, 2, -128, 127, 255, 0, 1, -1000, 1);
        add(1, 1, 5, 0, 64, 3, 1, 20, 0);
        // 24..28: lim_hi=100
        add(1, 2, 0, 0, 64, 2, 1, 0, 0);
        add(1, 2, 50, 0, 64, 0, 1, 50, 0);
        add(1, 2, 50, 0, 64, 0, 1, 100, 0);
        add(1, 2, 50, 0, 64, 0, 1, 100, 1);
        add(1, 2, 0, 120, 64, 0, 1, -20, 0);
        // 29: lim_lo > lim_hi
        add(1, 0, 0, 0, 64, 0, 1, 5, 1);
        // 30..33: hold reads after reset
        add(1, 0, 3, 0, 64, 1, 1, 0, 0);
        add(1, 1, 3, 0, 64, 1, 1, 0, 0);
        add(1, 2, 3, 0, 64, 1, 1, 0, 0);
        add(1, 3, 3, 0, 64, 1, 1, 0, 0);

        bus.in_valid = 0; bus.in_ch = 0; bus.rk = 0; bus.yk = 0;
        bus.ki = 0; bus.mode = 0;
        bus.lim_hi = 16'sd1000; bus.lim_lo = -16'sd1000;
        bus3.in_valid = 0; bus3.in_ch = 0; bus3.rk = 0; bus3.yk = 0;
        bus3.ki = 0; bus3.mode = 0;
        bus3.lim_hi = 16'sd1000; bus3.lim_lo = -16'sd1000;

        @(posedge clk);
        #1;
        check("rst_state", {bus.out_valid, bus.sat_flag, 2'(bus.out_ch), bus.ik}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_range(0, 23);
        bus.lim_hi = 16'sd100;
        run_range(24, 28);
        bus.lim_hi = -16'sd5;
        bus.lim_lo = 16'sd5;
        run_range(29, 29);
        bus.lim_hi = 16'sd1000;
        bus.lim_lo = -16'sd1000;

        // Odd channel count: index 3 is out of range and must vanish.
        bus3.in_valid = 1; bus3.in_ch = 3; bus3.rk = 7; bus3.ki = 64;
        @(posedge clk);
        #1;
        bus3.in_ch = 2; bus3.rk = 5;
        @(posedge clk);
        #1;
        bus3.in_valid = 0;
        @(posedge clk);
        #1;
        check("ch3_of_3_dropped", 32'(bus3.out_valid), 0);
        @(posedge clk);
        #1;
        check("ch2_of_3_valid", 32'(bus3.out_valid), 1);
        check("ch2_of_3_ik", bus3.ik, 5);
        check("ch2_of_3_ch", 32'(bus3.out_ch), 2);

        // Asynchronous reset with samples in flight.
        drive(vt[6]);
        @(posedge clk);
        #1;
        drive(vt[8]);
        @(posedge clk);
        #1;
        drive(vt[10]);
        #3;
        rst_n = 1'b0;
        bus.in_valid = 0;
        #1;
        check("in_rst_valid", 32'(bus.out_valid), 0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_valid%0d", k), 32'(bus.out_valid), 0);
        end
        check("post_rst_ik", bus.ik, 0);
        check("post_rst_sat", 32'(bus.sat_flag), 0);
        run_range(30, 33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
